// File: rtl/dot_add_share_arb.sv
// ============================================================================
// Module   : dot_add_share_arb
// Function : Round-robin arbiter sharing one signed a+b+CONST adder among
//            NREQ requesters through a 2-stage stallable pipeline.
// Revision : 1.0
// ============================================================================
`default_nettype none

module dot_add_share_arb #(
    parameter int SIZE  = 12,
    parameter int NREQ  = 4,
    parameter int CONST = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*SIZE-1:0]   req_a,
    input  logic [NREQ*SIZE-1:0]   req_b,
    output logic [NREQ-1:0]        rsp_valid,
    input  logic [NREQ-1:0]        rsp_ready,
    output logic [SIZE+1:0]        rsp_data,
    output logic                   busy
);

    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int SW  = SIZE + 2;
    localparam logic [NREQ-1:0] c_ONE_HOT = NREQ'(1);
    localparam logic [SW-1:0]   c_CONST   = SW'(CONST);

    // Modulo-NREQ increment of a requester index
    function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NREQ) begin
            s = s - NREQ;
        end
        return IDW'(s);
    endfunction

    // ---------------------------------------------------------------- state
    logic            s1_v_q,   s1_v_d;
    logic [SIZE-1:0] s1_a_q,   s1_a_d;
    logic [SIZE-1:0] s1_b_q,   s1_b_d;
    logic [IDW-1:0]  s1_id_q,  s1_id_d;
    logic            s2_v_q,   s2_v_d;
    logic [SW-1:0]   s2_sum_q, s2_sum_d;
    logic [IDW-1:0]  s2_id_q,  s2_id_d;
    logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;

    // ---------------------------------------------------------------- wires
    logic            w_s2_adv;
    logic            w_s1_adv;
    logic [NREQ-1:0] w_cand;
    logic            w_gnt_found;
    logic [IDW-1:0]  w_gnt_id;
    logic [SIZE-1:0] w_sel_a;
    logic [SIZE-1:0] w_sel_b;
    logic [SW-1:0]   w_sum;

    assign w_s2_adv = !s2_v_q || rsp_ready[s2_id_q];
    assign w_s1_adv = !s1_v_q || w_s2_adv;

    // rst_n gates candidates so req_ready is low while reset is asserted
    assign w_cand = (rst_n && en && w_s1_adv) ? req_valid : '0;

    // Scan from the farthest offset down so the nearest one at/after rr_ptr wins
    always_comb begin
        w_gnt_found = 1'b0;
        w_gnt_id    = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (w_cand[wrap_add(rr_ptr_q, k)]) begin
                w_gnt_found = 1'b1;
                w_gnt_id    = wrap_add(rr_ptr_q, k);
            end
        end
    end

    assign req_ready = w_gnt_found ? (c_ONE_HOT << w_gnt_id) : '0;
    assign w_sel_a   = req_a[int'(w_gnt_id)*SIZE +: SIZE];
    assign w_sel_b   = req_b[int'(w_gnt_id)*SIZE +: SIZE];

    assign w_sum = {{2{s1_a_q[SIZE-1]}}, s1_a_q}
                 + {{2{s1_b_q[SIZE-1]}}, s1_b_q}
                 + c_CONST;

    always_comb begin
        rr_ptr_d = w_gnt_found ? wrap_add(w_gnt_id, 1) : rr_ptr_q;

        s1_v_d  = s1_v_q;
        s1_a_d  = s1_a_q;
        s1_b_d  = s1_b_q;
        s1_id_d = s1_id_q;
        if (w_s1_adv) begin
            s1_v_d = w_gnt_found;
            if (w_gnt_found) begin
                s1_a_d  = w_sel_a;
                s1_b_d  = w_sel_b;
                s1_id_d = w_gnt_id;
            end
        end

        // Data only loads with a valid op so rsp_data stays quiet on bubbles
        s2_v_d   = s2_v_q;
        s2_sum_d = s2_sum_q;
        s2_id_d  = s2_id_q;
        if (w_s2_adv) begin
            s2_v_d = s1_v_q;
            if (s1_v_q) begin
                s2_sum_d = w_sum;
                s2_id_d  = s1_id_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q   <= 1'b0;
            s1_a_q   <= '0;
            s1_b_q   <= '0;
            s1_id_q  <= '0;
            s2_v_q   <= 1'b0;
            s2_sum_q <= '0;
            s2_id_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            s1_v_q   <= s1_v_d;
            s1_a_q   <= s1_a_d;
            s1_b_q   <= s1_b_d;
            s1_id_q  <= s1_id_d;
            s2_v_q   <= s2_v_d;
            s2_sum_q <= s2_sum_d;
            s2_id_q  <= s2_id_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign rsp_valid = s2_v_q ? (c_ONE_HOT << s2_id_q) : '0;
    assign rsp_data  = s2_sum_q;
    assign busy      = s1_v_q || s2_v_q;

endmodule

`default_nettype wire

// File: tb/tb_dot_add_share_arb.sv
// ============================================================================
// Module   : tb_dot_add_share_arb
// Function : Directed self-checking bench for dot_add_share_arb.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_dot_add_share_arb;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [47:0] req_a;
    logic [47:0] req_b;
    logic [3:0]  rsp_valid;
    logic [3:0]  rsp_ready;
    logic [13:0] rsp_data;
    logic        busy;

    int n_vec;
    int n_err;

    dot_add_share_arb #(.SIZE(12), .NREQ(4), .CONST(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [11:0] a, input logic [11:0] b);
        req_a[i*12 +: 12] = a;
        req_b[i*12 +: 12] = b;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; req_valid = 4'b1111; rsp_ready = 4'b1111;
        req_a = '0; req_b = '0;
        @(negedge clk);
        n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL reset_ready got %b want 0000", req_ready); end
        n_vec++; if (rsp_valid !== 4'b0000) begin n_err++; $display("FAIL reset_rsp_valid got %b want 0000", rsp_valid); end
        n_vec++; if (rsp_data !== 14'h0000) begin n_err++; $display("FAIL reset_rsp_data got %h want 0000", rsp_data); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
        cyc();
        req_valid = 4'b0000;
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        req_valid = 4'b0010; set_op(1, 12'd5, -12'sd3);
        @(negedge clk);
        n_vec++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL single_ready got %b want 0010", req_ready); end
        cyc(); req_valid = 4'b0000;
        @(negedge clk);
        n_vec++; if (rsp_valid !== 4'b0000) begin n_err++; $display("FAIL single_early got %b want 0000", rsp_valid); end
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy got %b want 1", busy); end
        cyc();
        @(negedge clk);
        n_vec++; if (rsp_valid !== 4'b0010) begin n_err++; $display("FAIL single_rsp_valid got %b want 0010", rsp_valid); end
        n_vec++; if (rsp_data !== 14'd3) begin n_err++; $display("FAIL single_rsp_data got %h want 0003", rsp_data); end
        cyc();
    endtask

    task automatic test_extremes();
        logic [11:0] ea [3];
        logic [11:0] eb [3];
        logic [13:0] ex [3];
        ea = '{12'h800, 12'h7FF, 12'hFFF};
        eb = '{12'h800, 12'h7FF, 12'h000};
        ex = '{14'h3001, 14'h0FFF, 14'h0000};
        for (int c = 0; c < 5; c++) begin
            if (c < 3) begin
                req_valid = 4'b0100; set_op(2, ea[c], eb[c]);
            end else begin
                req_valid = 4'b0000;
            end
            @(negedge clk);
            if (c < 3) begin
                n_vec++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL extreme_ready[%0d] got %b want 0100", c, req_ready); end
            end
            if (c >= 2) begin
                n_vec++; if (rsp_valid !== 4'b0100) begin n_err++; $display("FAIL extreme_valid[%0d] got %b want 0100", c-2, rsp_valid); end
                n_vec++; if (rsp_data !== ex[c-2]) begin n_err++; $display("FAIL extreme_data[%0d] got %h want %h", c-2, rsp_data, ex[c-2]); end
            end
            cyc();
        end
        cyc();
    endtask

    task automatic test_round_robin();
        rst_n = 1'b0; req_valid = 4'b0000;
        cyc();
        rst_n = 1'b1; rsp_ready = 4'b1111; req_valid = 4'b1111;
        for (int i = 0; i < 4; i++) set_op(i, 12'(i*10), 12'(i));
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            n_vec++; if (req_ready !== (4'b0001 << (c % 4))) begin n_err++; $display("FAIL rr_grant[%0d] got %b want %b", c, req_ready, 4'b0001 << (c % 4)); end
            if (c >= 2) begin
                n_vec++; if (rsp_valid !== (4'b0001 << ((c-2) % 4))) begin n_err++; $display("FAIL rr_rsp_valid[%0d] got %b want %b", c, rsp_valid, 4'b0001 << ((c-2) % 4)); end
                n_vec++; if (rsp_data !== 14'(((c-2) % 4) * 11 + 1)) begin n_err++; $display("FAIL rr_rsp_data[%0d] got %0d want %0d", c, rsp_data, ((c-2) % 4) * 11 + 1); end
            end
            cyc();
        end
        req_valid = 4'b0000;
        cyc(); cyc(); cyc();
    endtask

    task automatic test_backpressure();
        rsp_ready = 4'b1110;
        req_valid = 4'b0001; set_op(0, 12'd100, 12'd1);
        @(negedge clk);
        n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL bp_accept0 got %b want 0001", req_ready); end
        cyc(); set_op(0, 12'd200, 12'd2);
        @(negedge clk);
        n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL bp_accept1 got %b want 0001", req_ready); end
        cyc(); set_op(0, 12'd300, 12'd3);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_vec++; if (rsp_valid !== 4'b0001) begin n_err++; $display("FAIL bp_hold_valid[%0d] got %b want 0001", k, rsp_valid); end
            n_vec++; if (rsp_data !== 14'd102) begin n_err++; $display("FAIL bp_hold_data[%0d] got %0d want 102", k, rsp_data); end
            n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL bp_hold_ready[%0d] got %b want 0000", k, req_ready); end
            cyc();
        end
        rsp_ready = 4'b1111;
        @(negedge clk);
        n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL bp_release_ready got %b want 0001", req_ready); end
        n_vec++; if (rsp_data !== 14'd102) begin n_err++; $display("FAIL bp_rel0 got %0d want 102", rsp_data); end
        cyc(); req_valid = 4'b0000;
        @(negedge clk);
        n_vec++; if (rsp_valid !== 4'b0001 || rsp_data !== 14'd203) begin n_err++; $display("FAIL bp_rel1 got %b/%0d want 0001/203", rsp_valid, rsp_data); end
        cyc();
        @(negedge clk);
        n_vec++; if (rsp_valid !== 4'b0001 || rsp_data !== 14'd304) begin n_err++; $display("FAIL bp_rel2 got %b/%0d want 0001/304", rsp_valid, rsp_data); end
        cyc();
        @(negedge clk);
        n_vec++; if (rsp_valid !== 4'b0000 || busy !== 1'b0) begin n_err++; $display("FAIL bp_drained got %b/%b want 0000/0", rsp_valid, busy); end
        cyc();
    endtask

    task automatic test_en_gating();
        req_valid = 4'b0110;
        set_op(1, 12'd7, 12'd8); set_op(2, -12'sd10, 12'd4);
        @(negedge clk);
        n_vec++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL en_grant1 got %b want 0010", req_ready); end
        cyc(); req_valid = 4'b0100;
        @(negedge clk);
        n_vec++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL en_grant2 got %b want 0100", req_ready); end
        cyc(); en = 1'b0; req_valid = 4'b1111;
        @(negedge clk);
        n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL en_off_ready0 got %b want 0000", req_ready); end
        n_vec++; if (rsp_valid !== 4'b0010 || rsp_data !== 14'd16) begin n_err++; $display("FAIL en_rsp1 got %b/%h want 0010/0010", rsp_valid, rsp_data); end
        cyc();
        @(negedge clk);
        n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL en_off_ready1 got %b want 0000", req_ready); end
        n_vec++; if (rsp_valid !== 4'b0100 || rsp_data !== 14'h3FFB) begin n_err++; $display("FAIL en_rsp2 got %b/%h want 0100/3ffb", rsp_valid, rsp_data); end
        cyc();
        @(negedge clk);
        n_vec++; if (rsp_valid !== 4'b0000 || busy !== 1'b0) begin n_err++; $display("FAIL en_drained got %b/%b want 0000/0", rsp_valid, busy); end
        cyc(); en = 1'b1;
        @(negedge clk);
        n_vec++; if (req_ready !== 4'b1000) begin n_err++; $display("FAIL en_resume got %b want 1000", req_ready); end
        cyc();
        @(negedge clk);
        n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL en_wrap got %b want 0001", req_ready); end
        cyc(); req_valid = 4'b0000;
        cyc(); cyc(); cyc();
    endtask

    task automatic test_reset_midop();
        req_valid = 4'b1111;
        @(negedge clk);
        n_vec++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL rst_pre_grant got %b want 0010", req_ready); end
        cyc(); cyc();
        n_vec++; if (busy !== 1'b1 || rsp_valid !== 4'b0010) begin n_err++; $display("FAIL rst_pre_full got %b/%b want 1/0010", busy, rsp_valid); end
        #2 rst_n = 1'b0;
        #1;
        n_vec++; if (rsp_valid !== 4'b0000) begin n_err++; $display("FAIL rst_async_valid got %b want 0000", rsp_valid); end
        n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL rst_async_ready got %b want 0000", req_ready); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_async_busy got %b want 0", busy); end
        cyc();
        rst_n = 1'b1; set_op(0, 12'd20, 12'd22);
        @(negedge clk);
        n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL rst_after_grant got %b want 0001", req_ready); end
        cyc(); req_valid = 4'b0000;
        @(negedge clk);
        n_vec++; if (rsp_valid !== 4'b0000) begin n_err++; $display("FAIL rst_stale got %b want 0000", rsp_valid); end
        cyc();
        @(negedge clk);
        n_vec++; if (rsp_valid !== 4'b0001 || rsp_data !== 14'd43) begin n_err++; $display("FAIL rst_after_rsp got %b/%0d want 0001/43", rsp_valid, rsp_data); end
        cyc();
        @(negedge clk);
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_final_busy got %b want 0", busy); end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_single();
        test_extremes();
        test_round_robin();
        test_backpressure();
        test_en_gating();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
